z80_mcycle_fsm: RTL
===================

# z80_mcycle_fsm

Generalised Z80 machine-cycle sequencer and successor to the opcode-fetch FSM. It executes one bus machine cycle per request: M1 opcode fetch with refresh, memory read, memory write, I/O read or I/O write. It sits between the instruction decoder/control unit and the external bus pins, and drives all bus strobes, address and data. The block adds WAIT_L stretching, automatic I/O wait states, back-to-back cycles and parametrised widths.

## Interface
Parameters:
- ADDR_W, 16, address bus width
- DATA_W, 8, data bus width
- RFSH_W, 7, number of low R-register bits incremented per M1
- IO_WAITS, 1, mandatory TW states inserted in I/O cycles (0–3)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, one T-state per cycle
- rst  in  1  asynchronous active-high reset
- cyc_start  in  1  request a machine cycle
- cyc_type  in  3  cycle type: M1, MRD, MWR, IORD, IOWR (enum in package)
- cyc_addr  in  ADDR_W  cycle address
- cyc_wdata  in  DATA_W  write data
- i_reg  in  8  interrupt vector register, upper refresh address
- busy  out  1  cycle in progress
- cyc_done  out  1  high during the final T-state
- cyc_rdata  out  DATA_W  captured read data or opcode
- r_reg  out  8  refresh register
- data_in  in  DATA_W  bus read data
- WAIT_L  in  1  active-low wait request
- data_out  out  DATA_W  bus write data
- data_oe  out  1  data bus drive enable
- addr_out  out  ADDR_W  bus address
- M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L  out  1 each  active-low strobes

## Operation
- States: IDLE, T1, T2, TW, T3, T4. The wait counter and the latched type, address and wdata are held in registers.
- Request acceptance: cyc_start is sampled in IDLE or in the final T-state. The type, address and wdata are latched and the next state is T1. In any other state, cyc_start is ignored.
- Transitions:
  - T1 → T2.
  - T2 → TW if an I/O cycle has IO_WAITS>0 outstanding, or if WAIT_L=0. Otherwise T2 → T3.
  - TW stays in TW while auto-waits remain or WAIT_L=0. Otherwise TW → T3.
  - T3 → T4 for M1. For all other types, T3 is the final state.
  - T4 is the final state for M1.
  - Final state → T1 on a new request, otherwise IDLE.
- M1 cycle:
  - T1–TW: M1_L=0, MREQ_L=0, RD_L=0, addr_out=cyc_addr.
  - T3: M1_L=1, RD_L=1, MREQ_L=0, RFSH_L=0, addr_out={i_reg, r_reg} zero-extended to ADDR_W.
  - T4: MREQ_L=1, RFSH_L=0.
- MRD: MREQ_L=0 and RD_L=0 during T1–T3.
- MWR:
  - MREQ_L=0 and data_oe=1 during T1–T3.
  - WR_L=0 during T2–T3 (including TW).
  - data_out holds the latched wdata.
- IORD / IOWR: IORQ_L=0 with RD_L=0 (read) or WR_L=0 and data_oe=1 (write) during T2–T3 (including TW).
- Read capture: data_in is captured into cyc_rdata on the edge leaving T2 or the last TW, for M1, MRD and IORD. cyc_rdata holds until the next capture.
- R register: on the edge leaving T4, the low RFSH_W bits of r_reg increment and wrap modulo 2^RFSH_W. Bits above RFSH_W are unchanged.

## Timing
- Reset values: all strobes 1, addr_out=0, data_out=0, data_oe=0, busy=0, cyc_done=0, cyc_rdata=0, r_reg=0, state IDLE.
- Reset asserted mid-cycle deasserts every strobe asynchronously and abandons the cycle without a done pulse.
- Outputs are a pure decode of the registered state and latched type, so they are glitch-free and valid for the whole T-state.
- Zero-wait latency from cyc_start sampled to cyc_done high: M1 4 cycles, MRD/MWR 3, I/O 3+IO_WAITS. Each WAIT_L=0 sample adds 1 cycle.
- busy is high in T1 through the final state.
- Back-to-back cycles have no IDLE gap.
- WAIT_L is sampled only in T2/TW. It is ignored in T1, T3 and T4.

## Configuration
- Z80_RFSH_EN defined: M1 T3/T4 perform refresh as described.
- Z80_RFSH_EN not defined:
  - RFSH_L is tied 1.
  - addr_out holds cyc_addr through T3/T4.
  - MREQ_L goes high in T3.
  - r_reg stays 0.
  - M1 still takes 4 T-states.

## Structure
- Shared package z80_pkg holds:
  - the cyc_type_t enum (M1, MRD, MWR, IORD, IOWR);
  - the tstate_t enum;
  - the IO_WAITS limit constant.
- Sub-module z80_strobe_decode: combinational strobe, address and oe decode from state and type.

## Test plan
- M1 at addr 0xbeef, i_reg=0x3a, r_reg=0x7f, data_in=0xc3, WAIT_L=1 → done in cycle 4, cyc_rdata=0xc3, T3 addr_out=0x3a7f, then r_reg=0x00 (bit 7 preserved).
- MRD at 0x1234 with WAIT_L=0 for 2 samples → two TW states, done in cycle 5, read data captured when leaving the last TW.
- MWR 0x55 to 0x8000 → WR_L low in cycles 2–3, data_oe high in 1–3, data_out=0x55.
- IORD with IO_WAITS=1, then IOWR issued during the final T-state → IORQ_L low in cycles 2–4, next T1 follows immediately, busy never drops.
- rst asserted in T2 of MWR → WR_L, MREQ_L and data_oe go to 1 immediately, no cyc_done; after release, an M1 completes normally.
- Build without Z80_RFSH_EN, M1 → RFSH_L stays 1, addr_out=cyc_addr in T3/T4, r_reg stays 0.

Source files
------------

// File: rtl/z80_pkg.sv
// Shared types for the Z80 machine-cycle sequencer.
// Z80_RFSH_EN selects whether M1 cycles perform DRAM refresh.
package z80_pkg;

    typedef enum logic [2:0] {
        CYC_M1   = 3'd0,
        CYC_MRD  = 3'd1,
        CYC_MWR  = 3'd2,
        CYC_IORD = 3'd3,
        CYC_IOWR = 3'd4
    } cyc_type_t;

    typedef enum logic [2:0] {
        TS_IDLE = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_TW   = 3'd3,
        TS_T3   = 3'd4,
        TS_T4   = 3'd5
    } tstate_t;

    localparam int IO_WAITS_MAX = 3;

`ifdef Z80_RFSH_EN
    localparam bit RFSH_EN = 1'b1;
`else
    localparam bit RFSH_EN = 1'b0;
`endif

    function automatic logic is_io(input cyc_type_t t);
        return (t == CYC_IORD) || (t == CYC_IOWR);
    endfunction

endpackage

// File: rtl/z80_strobe_decode.sv
// Bus strobe and drive-enable decode from T-state and cycle type.
// Refresh strobes are active only when Z80_RFSH_EN is defined.
module z80_strobe_decode
    import z80_pkg::*;
(
    input  tstate_t   i_state,
    input  cyc_type_t i_type,
    output logic      o_m1_l,
    output logic      o_mreq_l,
    output logic      o_iorq_l,
    output logic      o_rd_l,
    output logic      o_wr_l,
    output logic      o_rfsh_l,
    output logic      o_data_oe,
    output logic      o_rfsh_sel
);

    logic w_early;
    logic w_late;
    logic w_body;

    assign w_early = (i_state == TS_T1) || (i_state == TS_T2)
                   || (i_state == TS_TW);
    assign w_late  = (i_state == TS_T2) || (i_state == TS_TW)
                   || (i_state == TS_T3);
    assign w_body  = w_early || (i_state == TS_T3);

    always_comb begin
        o_m1_l     = 1'b1;
        o_mreq_l   = 1'b1;
        o_iorq_l   = 1'b1;
        o_rd_l     = 1'b1;
        o_wr_l     = 1'b1;
        o_rfsh_l   = 1'b1;
        o_data_oe  = 1'b0;
        o_rfsh_sel = 1'b0;
        unique case (1'b1)
            (i_type == CYC_M1): begin
                if (w_early) begin
                    o_m1_l   = 1'b0;
                    o_mreq_l = 1'b0;
                    o_rd_l   = 1'b0;
                end
                // Refresh half of M1: T3 strobes MREQ, T4 keeps RFSH only
                if (RFSH_EN && i_state == TS_T3) begin
                    o_mreq_l   = 1'b0;
                    o_rfsh_l   = 1'b0;
                    o_rfsh_sel = 1'b1;
                end
                if (RFSH_EN && i_state == TS_T4) begin
                    o_rfsh_l = 1'b0;
                end
            end
            (i_type == CYC_MRD): begin
                if (w_body) begin
                    o_mreq_l = 1'b0;
                    o_rd_l   = 1'b0;
                end
            end
            (i_type == CYC_MWR): begin
                if (w_body) begin
                    o_mreq_l  = 1'b0;
                    o_data_oe = 1'b1;
                end
                if (w_late) begin
                    o_wr_l = 1'b0;
                end
            end
            (i_type == CYC_IORD): begin
                if (w_late) begin
                    o_iorq_l = 1'b0;
                    o_rd_l   = 1'b0;
                end
            end
            (i_type == CYC_IOWR): begin
                if (w_late) begin
                    o_iorq_l  = 1'b0;
                    o_wr_l    = 1'b0;
                    o_data_oe = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/z80_mcycle_fsm.sv
// Z80 machine-cycle sequencer: M1, MRD, MWR, IORD, IOWR with waits.
// Z80_RFSH_EN enables M1 refresh (RFSH_L, refresh address, R increment).
module z80_mcycle_fsm
    import z80_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int RFSH_W   = 7,
    parameter int IO_WAITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_start,
    input  cyc_type_t         cyc_type,
    input  logic [ADDR_W-1:0] cyc_addr,
    input  logic [DATA_W-1:0] cyc_wdata,
    input  logic [7:0]        i_reg,
    output logic              busy,
    output logic              cyc_done,
    output logic [DATA_W-1:0] cyc_rdata,
    output logic [7:0]        r_reg,
    input  logic [DATA_W-1:0] data_in,
    input  logic              WAIT_L,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic [ADDR_W-1:0] addr_out,
    output logic              M1_L,
    output logic              MREQ_L,
    output logic              IORQ_L,
    output logic              RD_L,
    output logic              WR_L,
    output logic              RFSH_L
);

    localparam logic [7:0] RMASK = 8'((1 << RFSH_W) - 1);
    localparam logic [1:0] IOW   = 2'(IO_WAITS);

    tstate_t           r_state;
    cyc_type_t         r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_wait;
    logic [7:0]        r_r;

    logic              w_final;
    logic              w_open;
    logic              w_stall;
    logic              w_capture;
    logic              w_rfsh_sel;
    logic [7:0]        w_r_next;
    logic [15:0]       w_rf_full;

    assign w_final   = (r_state == TS_T4)
                     || (r_state == TS_T3 && r_type != CYC_M1);
    assign w_open    = (r_state == TS_IDLE) || w_final;
    assign w_stall   = (r_wait != 2'd0) || !WAIT_L;
    assign w_capture = (r_type == CYC_M1) || (r_type == CYC_MRD)
                     || (r_type == CYC_IORD);
    assign w_r_next  = (r_r & ~RMASK) | ((r_r + 8'd1) & RMASK);
    assign w_rf_full = {i_reg, r_r};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TS_IDLE;
            r_type  <= CYC_M1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wait  <= 2'd0;
            r_r     <= 8'd0;
        end else if (w_open) begin
            if (RFSH_EN && r_state == TS_T4) begin
                r_r <= w_r_next;
            end
            if (cyc_start) begin
                r_state <= TS_T1;
                r_type  <= cyc_type;
                r_addr  <= cyc_addr;
                r_wdata <= cyc_wdata;
                r_wait  <= is_io(cyc_type) ? IOW : 2'd0;
            end else begin
                r_state <= TS_IDLE;
            end
        end else begin
            case (r_state)
                TS_T1: r_state <= TS_T2;
                TS_T2, TS_TW: begin
                    // Auto I/O waits drain first; WAIT_L can extend further
                    if (w_stall) begin
                        r_state <= TS_TW;
                        if (r_wait != 2'd0) begin
                            r_wait <= r_wait - 2'd1;
                        end
                    end else begin
                        r_state <= TS_T3;
                        if (w_capture) begin
                            r_rdata <= data_in;
                        end
                    end
                end
                TS_T3:   r_state <= TS_T4;
                default: r_state <= TS_IDLE;
            endcase
        end
    end

    z80_strobe_decode u_dec (
        .i_state    (r_state),
        .i_type     (r_type),
        .o_m1_l     (M1_L),
        .o_mreq_l   (MREQ_L),
        .o_iorq_l   (IORQ_L),
        .o_rd_l     (RD_L),
        .o_wr_l     (WR_L),
        .o_rfsh_l   (RFSH_L),
        .o_data_oe  (data_oe),
        .o_rfsh_sel (w_rfsh_sel)
    );

    assign addr_out  = w_rfsh_sel ? ADDR_W'(w_rf_full) : r_addr;
    assign data_out  = r_wdata;
    assign cyc_rdata = r_rdata;
    assign r_reg     = r_r;
    assign busy      = (r_state != TS_IDLE);
    assign cyc_done  = w_final;

endmodule
